wishbone_arbiter: RTL and testbench

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/rr_select.sv | 12 +
 rtl/wishbone_arbiter.sv | 136 +++++++++++++
 tb/tb_wishbone_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared state encoding and defaults for the wishbone arbiter
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // One spare bit so the saturating counter can sit above the abort threshold.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - two-way round-robin pick favouring the master not served last
module rr_select (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  assign valid = |req;
  assign pick  = (&req) ? ~last : req[1];

endmodule

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - two-master wishbone arbiter with stalled-strobe abort
module wishbone_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0]    m0_dat_i,
  output logic [DATA_WIDTH-1:0]    m0_dat_o,
  input  logic                     m0_we_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_cyc_i,
  input  logic [DATA_BYTES-1:0]    m0_sel_i,
  input  logic [2:0]               m0_cti_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0]    m1_dat_i,
  output logic [DATA_WIDTH-1:0]    m1_dat_o,
  input  logic                     m1_we_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_cyc_i,
  input  logic [DATA_BYTES-1:0]    m1_sel_i,
  input  logic [2:0]               m1_cti_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [ADDRESS_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0]    s_dat_o,
  output logic [DATA_BYTES-1:0]    s_sel_o,
  output logic [2:0]               s_cti_o,
  output logic                     s_we_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic [DATA_WIDTH-1:0]    s_dat_i,
  input  logic                     s_ack_i
);

  localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  arb_state_t    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          req_valid, req_pick;
  logic          g_cyc, g_stb, in_grant, timeout;

  rr_select u_rr_select (
    .req   ({m1_cyc_i, m0_cyc_i}),
    .last  (last_q),
    .valid (req_valid),
    .pick  (req_pick)
  );

  assign g_cyc    = grant_q ? m1_cyc_i : m0_cyc_i;
  assign g_stb    = grant_q ? m1_stb_i : m0_stb_i;
  assign in_grant = (state_q == GRANT);
  // A late ack on the threshold cycle still completes the beat.
  assign timeout  = g_cyc & g_stb & ~s_ack_i & (cnt_q == CNT_LAST);

  assign s_adr_o  = grant_q ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = grant_q ? m1_dat_i : m0_dat_i;
  assign s_sel_o  = grant_q ? m1_sel_i : m0_sel_i;
  assign s_cti_o  = grant_q ? m1_cti_i : m0_cti_i;
  assign s_we_o   = in_grant & (grant_q ? m1_we_i : m0_we_i);
  assign s_stb_o  = in_grant & g_stb;
  assign s_cyc_o  = in_grant & g_cyc;

  assign m0_ack_o = s_ack_i & m0_cyc_i & in_grant & ~grant_q;
  assign m1_ack_o = s_ack_i & m1_cyc_i & in_grant & grant_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = GRANT;
          grant_d = req_pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (timeout) begin
          state_d        = ABORT;
          err_d[grant_q] = 1'b1;
        end else if (s_ack_i || !g_stb) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ABORT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - scoreboard bench for the two-master wishbone arbiter
module tb_wishbone_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] m_adr [2];
  logic [7:0]  m_dat [2];
  logic        m_we  [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic [0:0]  m_sel [2];
  logic [2:0]  m_cti [2];
  logic [7:0]  m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [15:0] s_adr_o;
  logic [7:0]  s_dat_o, s_dat_i;
  logic [0:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;

  typedef struct {
    int          m;
    bit          err;
    bit          we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  wishbone_arbiter dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .m0_adr_i (m_adr[0]),
    .m0_dat_i (m_dat[0]),
    .m0_dat_o (m0_dat_o),
    .m0_we_i  (m_we[0]),
    .m0_stb_i (m_stb[0]),
    .m0_cyc_i (m_cyc[0]),
    .m0_sel_i (m_sel[0]),
    .m0_cti_i (m_cti[0]),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_adr_i (m_adr[1]),
    .m1_dat_i (m_dat[1]),
    .m1_dat_o (m1_dat_o),
    .m1_we_i  (m_we[1]),
    .m1_stb_i (m_stb[1]),
    .m1_cyc_i (m_cyc[1]),
    .m1_sel_i (m_sel[1]),
    .m1_cti_i (m_cti[1]),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_cti_o  (s_cti_o),
    .s_we_o   (s_we_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: acks after slave_wait stalled cycles; slave_en=0 models a hung slave.
  logic [7:0] mem [256];
  int         wait_cnt = 0;
  int         slave_wait;
  bit         slave_en;

  assign s_ack_i = slave_en && s_stb_o && (wait_cnt >= slave_wait);
  assign s_dat_i = mem[s_adr_o[7:0]];

  always @(posedge clk) begin
    if (s_stb_o && !s_ack_i) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (s_ack_i && s_we_o) mem[s_adr_o[7:0]] <= s_dat_o;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_ack(input int m, input bit we, input logic [15:0] adr, input logic [7:0] dat);
    exp_q.push_back('{m, 1'b0, we, adr, dat});
  endtask

  task automatic expect_err(input int m);
    exp_q.push_back('{m, 1'b1, 1'b0, 16'h0000, 8'h00});
  endtask

  // Monitor: every ack/err the DUT presents must match the head of the queue.
  initial begin
    logic [1:0] acks, errs, want;
    logic [7:0] rdat;
    bit         ok;
    forever begin
      @(negedge clk);
      acks = {m1_ack_o, m0_ack_o};
      errs = {m1_err_o, m0_err_o};
      if ((acks | errs) != 2'b00) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_response: ack=%b err=%b, expected none", acks, errs);
        end else begin
          e    = exp_q.pop_front();
          want = 2'b01 << e.m;
          rdat = (e.m == 1) ? m1_dat_o : m0_dat_o;
          if (e.err) ok = (errs == want) && (acks == 2'b00);
          else       ok = (acks == want) && (errs == 2'b00) && (s_adr_o == e.adr) &&
                          (e.we ? (s_dat_o == e.dat) : (rdat == e.dat));
          if (!ok) begin
            n_bad++;
            $display("FAIL response_m%0d: ack=%b err=%b adr=%h wdat=%h rdat=%h, expected %s adr=%h dat=%h",
                     e.m, acks, errs, s_adr_o, s_dat_o, rdat, e.err ? "err" : "ack", e.adr, e.dat);
          end
        end
      end
    end
  end

  // Master driver: holds cyc/stb until all beats are acked; returns one cycle after dropping cyc.
  task automatic m_xfer(input int n, input logic we, input logic [15:0] adr, input logic [7:0] dat,
                        input int beats, output int lat);
    int done  = 0;
    int cyc_n = 0;
    lat = -1;
    m_cyc[n] = 1'b1; m_stb[n] = 1'b1; m_we[n] = we; m_adr[n] = adr; m_dat[n] = dat;
    m_sel[n] = 1'b1; m_cti[n] = (beats > 1) ? 3'b010 : 3'b111;
    while (done < beats && cyc_n < 300) begin
      @(negedge clk);
      cyc_n++;
      if ((n == 0) ? m0_ack_o : m1_ack_o) begin
        if (lat < 0) lat = cyc_n;
        done++;
      end
      @(posedge clk); #1;
      m_adr[n] = adr + 16'(done);
      m_dat[n] = dat + 8'(done);
      if (done == beats - 1) m_cti[n] = 3'b111;
    end
    m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
    if (done < beats) begin
      n_cmp++;
      n_bad++;
      $display("FAIL xfer_m%0d_stalled: got %0d beats, expected %0d", n, done, beats);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1);
  end

  initial begin
    int lat_a, lat_b, n, cnt;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 1'b0; m_stb[i] = 1'b0;
      m_cyc[i] = 1'b0; m_sel[i] = '0; m_cti[i] = '0;
    end
    slave_en   = 1'b1;
    slave_wait = 0;
    rst_n      = 1'b0;
    @(negedge clk);
    chk("in_reset_outputs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}, 4'b0);
    do_reset();
    @(negedge clk);
    chk("after_reset_outputs", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 7'b0);
    @(posedge clk); #1;

    // Single m0 write then readback; ack lands on the second sampled cycle.
    expect_ack(0, 1'b1, 16'h0010, 8'hA5);
    m_xfer(0, 1'b1, 16'h0010, 8'hA5, 1, lat_a);
    chk("m0_write_latency", lat_a, 2);
    expect_ack(0, 1'b0, 16'h0010, 8'hA5);
    m_xfer(0, 1'b0, 16'h0010, 8'h00, 1, lat_a);

    // Ties after reset: m0 first, then m1, then m0 wins the next tie.
    do_reset();
    expect_ack(0, 1'b1, 16'h0020, 8'h11);
    expect_ack(1, 1'b1, 16'h0021, 8'h22);
    fork
      m_xfer(0, 1'b1, 16'h0020, 8'h11, 1, lat_a);
      m_xfer(1, 1'b1, 16'h0021, 8'h22, 1, lat_b);
    join
    chk("tie1_m0_latency", lat_a, 2);
    expect_ack(0, 1'b1, 16'h0022, 8'h33);
    expect_ack(1, 1'b1, 16'h0023, 8'h44);
    fork
      m_xfer(0, 1'b1, 16'h0022, 8'h33, 1, lat_a);
      m_xfer(1, 1'b1, 16'h0023, 8'h44, 1, lat_b);
    join
    chk("tie2_m0_latency", lat_a, 2);

    // m1 4-beat burst is never split by m0 requesting one cycle later.
    for (int i = 0; i < 4; i++) expect_ack(1, 1'b1, 16'h0030 + 16'(i), 8'h40 + 8'(i));
    expect_ack(0, 1'b0, 16'h0032, 8'h42);
    fork
      m_xfer(1, 1'b1, 16'h0030, 8'h40, 4, lat_b);
      begin
        @(posedge clk); #1;
        m_xfer(0, 1'b0, 16'h0032, 8'h00, 1, lat_a);
      end
    join
    chk("burst_m1_latency", lat_b, 2);

    // Ack arriving on the threshold cycle completes normally.
    slave_wait = 15;
    expect_ack(1, 1'b1, 16'h0060, 8'h5A);
    m_xfer(1, 1'b1, 16'h0060, 8'h5A, 1, lat_b);
    chk("late_ack_latency", lat_b, 17);
    slave_wait = 0;

    // Hung slave: err pulse 16 cycles after strobe reaches the slave, then ABORT until cyc drops.
    slave_en = 1'b0;
    expect_err(0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 16'h0050; m_dat[0] = 8'h77;
    n = 0;
    while (!s_stb_o && n < 20) begin @(negedge clk); n++; end
    chk("stuck_stb_seen", s_stb_o, 1'b1);
    cnt = 0;
    while (!m0_err_o && cnt < 100) begin @(negedge clk); cnt++; end
    chk("timeout_cycles", cnt, 16);
    slave_en = 1'b1;
    @(negedge clk);
    chk("err_single_pulse", {m0_err_o, s_cyc_o, s_stb_o}, 3'b0);
    repeat (3) @(negedge clk);
    chk("abort_holds_deselect", {s_cyc_o, s_stb_o, m0_ack_o}, 3'b0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    @(posedge clk); #1;
    expect_ack(0, 1'b0, 16'h0060, 8'h5A);
    m_xfer(0, 1'b0, 16'h0060, 8'h00, 1, lat_a);
    chk("recover_latency", lat_a, 2);

    // Reset mid-burst deselects the slave at once and restores m0 tie priority.
    slave_en = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 16'h0070; m_cti[1] = 3'b010;
    n = 0;
    while (!s_cyc_o && n < 20) begin @(negedge clk); n++; end
    chk("rst_pre_grant", s_cyc_o, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 slave_en = 1'b1;
    @(negedge clk);
    chk("rst_mid_burst", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 7'b0);
    @(posedge clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    rst_n = 1'b1;
    expect_ack(0, 1'b1, 16'h0071, 8'h01);
    expect_ack(1, 1'b1, 16'h0072, 8'h02);
    fork
      m_xfer(0, 1'b1, 16'h0071, 8'h01, 1, lat_a);
      m_xfer(1, 1'b1, 16'h0072, 8'h02, 1, lat_b);
    join
    chk("post_reset_tie_m0", lat_a, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
